// File: rtl/fract_resampler.sv
// Purpose: linear-interpolating I/Q resampler with fractional phase step, plus a register-slice bypass.
// Latency: 2 cycles from the second fill sample to the first output when interpolating; 1 cycle in bypass.
// Backpressure: o_tdata is held until i_rdy; input is refused in CALC/OUT, and in bypass while a held output is not taken.
module fract_resampler #(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 12,
    parameter int SR_BASE = 192
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic [WIDTH-1:0]     i_din_i,
    input  logic [WIDTH-1:0]     i_din_q,
    input  logic                 i_din_vld,
    output logic                 o_rdy,
    output logic [2*WIDTH-1:0]   o_tdata,
    output logic                 o_tvalid,
    input  logic                 i_rdy,
    input  logic                 i_set_stb,
    input  logic [7:0]           i_set_addr,
    input  logic [31:0]          i_set_data,
    output logic [31:0]          o_out_cnt
);

    localparam int PROD_W = WIDTH + PHASE_W + 2;
    localparam logic [PHASE_W:0] STEP_ONE = {1'b1, {PHASE_W{1'b0}}};
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) << (PHASE_W - 1);

    typedef struct packed {
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] q;
    } iq_t;

    typedef enum logic [2:0] {S_FILL, S_CALC, S_OUT, S_LOAD, S_BYP} state_t;

    logic [1:0] rst_sync;
    logic       rst_int_n;

    state_t                     state;
    logic                       bypass;
    logic [PHASE_W:0]           step;
    logic [PHASE_W:0]           step_new;
    logic [PHASE_W-1:0]         mu;
    logic [PHASE_W:0]           mu_sum;
    logic signed [PHASE_W:0]    mu_s;
    iq_t                        x0;
    iq_t                        x1;
    iq_t                        din;
    logic signed [WIDTH:0]      diff_i;
    logic signed [WIDTH:0]      diff_q;
    logic signed [PROD_W-1:0]   prod_i;
    logic signed [PROD_W-1:0]   prod_q;
    logic signed [PROD_W-1:0]   prod_nxt_i;
    logic signed [PROD_W-1:0]   prod_nxt_q;
    logic [WIDTH-1:0]           y_i;
    logic [WIDTH-1:0]           y_q;
    logic                       fill_cnt;
    logic                       out_vld;
    logic [31:0]                out_cnt;
    logic                       in_xfer;
    logic                       out_xfer;
    logic                       step_wr;
    logic                       mode_wr;
    logic                       byp_next;
    logic                       cnt_clr;
    logic                       do_clr;

    // Release is delayed two edges so the core never sees a partial reset exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    assign din      = {i_din_i, i_din_q};
    assign o_rdy    = (state == S_FILL) || (state == S_LOAD) ||
                      ((state == S_BYP) && (!out_vld || i_rdy));
    assign in_xfer  = i_din_vld && o_rdy;
    assign out_xfer = out_vld && i_rdy;

    assign step_wr  = i_set_stb && (i_set_addr == 8'(SR_BASE));
    assign mode_wr  = i_set_stb && (i_set_addr == 8'(SR_BASE + 1));
    assign byp_next = mode_wr ? i_set_data[0] : bypass;
    assign cnt_clr  = i_clear || (mode_wr && i_set_data[1]);
    assign do_clr   = cnt_clr || (mode_wr && (i_set_data[0] != bypass));

    always_comb begin
        step_new = i_set_data[PHASE_W:0];
        if (i_set_data == 32'd0) begin
            step_new = (PHASE_W+1)'(1);
        end else if (i_set_data > 32'(STEP_ONE)) begin
            step_new = STEP_ONE;
        end
    end

    assign diff_i     = $signed({x1.i[WIDTH-1], x1.i}) - $signed({x0.i[WIDTH-1], x0.i});
    assign diff_q     = $signed({x1.q[WIDTH-1], x1.q}) - $signed({x0.q[WIDTH-1], x0.q});
    assign mu_s       = $signed({1'b0, mu});
    assign prod_nxt_i = PROD_W'(diff_i) * PROD_W'(mu_s);
    assign prod_nxt_q = PROD_W'(diff_q) * PROD_W'(mu_s);
    assign mu_sum     = {1'b0, mu} + step;

    // Interpolant always lies between x0 and x1, so plain truncation cannot wrap.
    assign y_i = x0.i + WIDTH'((prod_i + HALF) >>> PHASE_W);
    assign y_q = x0.q + WIDTH'((prod_q + HALF) >>> PHASE_W);

    assign o_tdata   = out_vld ? {y_i, y_q} : '0;
    assign o_tvalid  = out_vld;
    assign o_out_cnt = out_cnt;

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= S_FILL;
            bypass   <= 1'b0;
            step     <= STEP_ONE;
            mu       <= '0;
            x0       <= '0;
            x1       <= '0;
            prod_i   <= '0;
            prod_q   <= '0;
            fill_cnt <= 1'b0;
            out_vld  <= 1'b0;
            out_cnt  <= '0;
        end else begin
            if (step_wr) begin
                step <= step_new;
            end
            if (mode_wr) begin
                bypass <= i_set_data[0];
            end
            if (cnt_clr) begin
                out_cnt <= '0;
            end else if (out_xfer) begin
                out_cnt <= out_cnt + 32'd1;
            end

            if (do_clr) begin
                state    <= byp_next ? S_BYP : S_FILL;
                mu       <= '0;
                x0       <= '0;
                x1       <= '0;
                prod_i   <= '0;
                prod_q   <= '0;
                fill_cnt <= 1'b0;
                out_vld  <= 1'b0;
            end else begin
                case (state)
                    S_FILL: begin
                        if (in_xfer) begin
                            x0       <= x1;
                            x1       <= din;
                            fill_cnt <= 1'b1;
                            if (fill_cnt) begin
                                fill_cnt <= 1'b0;
                                mu       <= '0;
                                state    <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        prod_i  <= prod_nxt_i;
                        prod_q  <= prod_nxt_q;
                        out_vld <= 1'b1;
                        state   <= S_OUT;
                    end
                    S_OUT: begin
                        if (out_xfer) begin
                            out_vld <= 1'b0;
                            mu      <= mu_sum[PHASE_W-1:0];
                            state   <= mu_sum[PHASE_W] ? S_LOAD : S_CALC;
                        end
                    end
                    S_LOAD: begin
                        if (in_xfer) begin
                            x0    <= x1;
                            x1    <= din;
                            state <= S_CALC;
                        end
                    end
                    S_BYP: begin
                        // prod stays zero here, so the output path presents x0 unchanged.
                        if (in_xfer) begin
                            x0      <= din;
                            out_vld <= 1'b1;
                        end else if (out_xfer) begin
                            out_vld <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fract_resampler.sv
// Scoreboarded bench for fract_resampler: directed cases plus randomized segments against an arithmetic model.
module tb_fract_resampler;

    localparam int SR_BASE = 192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] din_i = '0;
    logic [15:0] din_q = '0;
    logic        din_vld = 1'b0;
    logic        o_rdy;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        i_rdy;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] o_out_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt_model = 0;
    int          rdy_mode = 1;
    logic [31:0] exp_q[$];
    int          seg_i[$];
    int          seg_q[$];

    fract_resampler #(.WIDTH(16), .PHASE_W(12), .SR_BASE(SR_BASE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr),
        .i_din_i(din_i), .i_din_q(din_q), .i_din_vld(din_vld),
        .o_rdy(o_rdy), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_rdy(i_rdy),
        .i_set_stb(set_stb), .i_set_addr(set_addr), .i_set_data(set_data),
        .o_out_cnt(o_out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] iq(input int i, input int q);
        return {16'(i), 16'(q)};
    endfunction

    // x[j] + round-half-up((x[j+1]-x[j]) * mu / 4096), floor division for negatives
    function automatic logic [15:0] interp(input int a, input int b, input int mu);
        longint num, q;
        num = (longint'(b) - longint'(a)) * longint'(mu) + 64'sd2048;
        q = num / 4096;
        if (num < 0 && (num % 4096) != 0) q = q - 1;
        return 16'(longint'(a) + q);
    endfunction

    function automatic int eff_step(input int unsigned w);
        if (w == 0) return 1;
        if (w > 4096) return 4096;
        return int'(w);
    endfunction

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
        cnt_model++;
    endtask

    // Output n sits at input position n*step/4096; it exists once both neighbours have arrived.
    task automatic push_interp(input int step);
        int n;
        n = seg_i.size();
        for (int p = 0; p < (n - 1) * 4096; p += step) begin
            int j, mu;
            j = p / 4096;
            mu = p % 4096;
            push_exp({interp(seg_i[j], seg_i[j+1], mu), interp(seg_q[j], seg_q[j+1], mu)});
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && o_tvalid && i_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, none expected", o_tdata);
                end else begin
                    check("sample", o_tdata, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic rdy_driver();
        i_rdy = 1'b1;
        forever begin
            tick();
            case (rdy_mode)
                0: i_rdy = 1'b0;
                1: i_rdy = 1'b1;
                default: i_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic send(input int si, input int sq, input int gap);
        int t;
        repeat ($urandom_range(0, gap)) tick();
        din_i = 16'(si);
        din_q = 16'(sq);
        din_vld = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (o_rdy) break;
            t++;
            if (t > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: input %0d not accepted, required within 20000 cycles", si);
                break;
            end
        end
        tick();
        din_vld = 1'b0;
    endtask

    task automatic set_write(input int addr, input int unsigned data);
        set_stb = 1'b1;
        set_addr = 8'(addr);
        set_data = data;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt_model = 0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) tick();
        @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, 32'(o_tvalid), 0);
        check({name, "_out_cnt"}, o_out_cnt, cnt_model);
        tick();
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!o_tvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_vld"}, 32'(o_tvalid), 1);
    endtask

    task automatic run_segment(input bit byp, input int unsigned step_raw, input int n, input int gap);
        set_write(SR_BASE + 1, byp);
        set_write(SR_BASE, step_raw);
        pulse_clear();
        seg_i.delete();
        seg_q.delete();
        for (int k = 0; k < n; k++) begin
            seg_i.push_back(int'($urandom_range(0, 65535)) - 32768);
            seg_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
        if (byp) begin
            for (int k = 0; k < n; k++) push_exp(iq(seg_i[k], seg_q[k]));
        end else begin
            push_interp(eff_step(step_raw));
        end
        for (int k = 0; k < n; k++) send(seg_i[k], seg_q[k], gap);
        wait_drain(byp ? "rand_byp" : "rand_interp");
    endtask

    initial begin
        logic [31:0] held;
        fork
            monitor();
            rdy_driver();
        join_none

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 32'(o_rdy), 1);
        check("rst_tvalid", 32'(o_tvalid), 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_out_cnt", o_out_cnt, 0);

        // A sample offered at the first edge after release must be ignored.
        tick();
        rst_n = 1'b1;
        din_i = 16'd999;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        repeat (2) tick();

        // Default unity step
        push_exp(iq(100, 0));
        push_exp(iq(200, 0));
        send(100, 0, 0); send(200, 0, 0); send(300, 0, 0);
        wait_drain("unity");

        // Half step, then a negative rounding case
        set_write(SR_BASE, 2048);
        pulse_clear();
        push_exp(iq(0, 0)); push_exp(iq(500, 0)); push_exp(iq(1000, 0)); push_exp(iq(1500, 0));
        send(0, 0, 0); send(1000, 0, 0); send(2000, 0, 0);
        wait_drain("half");
        pulse_clear();
        push_exp(iq(0, 0)); push_exp(iq(-1, 0));
        send(0, 0, 0); send(-3, 0, 0);
        wait_drain("neg_round");

        // Step 1365: phase carries 1364 into the next interval
        set_write(SR_BASE, 1365);
        pulse_clear();
        push_exp(iq(0, 0)); push_exp(iq(1365, 0)); push_exp(iq(2730, 0)); push_exp(iq(4095, 0));
        send(0, 0, 0); send(4096, 0, 0);
        wait_drain("third_a");
        push_exp(iq(5460, 0)); push_exp(iq(6825, 0)); push_exp(iq(8190, 0));
        send(8192, 0, 0);
        wait_drain("third_b");

        // Downstream stall during OUT
        set_write(SR_BASE, 2048);
        pulse_clear();
        rdy_mode = 0;
        repeat (2) tick();
        push_exp(iq(100, 0)); push_exp(iq(600, 0)); push_exp(iq(1100, 0)); push_exp(iq(1600, 0));
        send(100, 0, 0); send(1100, 0, 0);
        wait_valid("stall");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_tvalid", 32'(o_tvalid), 1);
            check("stall_tdata", o_tdata, iq(100, 0));
            check("stall_rdy", 32'(o_rdy), 0);
            check("stall_out_cnt", o_out_cnt, 0);
        end
        tick();
        rdy_mode = 1;
        send(2100, 0, 0);
        wait_drain("stall");

        // Bypass: back-to-back samples, one cycle latency
        set_write(SR_BASE + 1, 1);
        pulse_clear();
        push_exp(iq(7, 0)); push_exp(iq(8, 0)); push_exp(iq(9, 0));
        din_q = 16'd0;
        din_i = 16'd7;
        din_vld = 1'b1;
        @(negedge clk);
        check("byp_rdy", 32'(o_rdy), 1);
        tick();
        din_i = 16'd8;
        @(negedge clk);
        check("byp_lat_7", 32'(o_tvalid), 1);
        tick();
        din_i = 16'd9;
        @(negedge clk);
        check("byp_lat_8", 32'(o_tvalid), 1);
        tick();
        din_vld = 1'b0;
        @(negedge clk);
        check("byp_lat_9", 32'(o_tvalid), 1);
        tick();
        wait_drain("byp");

        // Randomized segments, including the step-write boundaries
        rdy_mode = 2;
        for (int s = 0; s < 8; s++) begin
            run_segment(s % 3 == 2, $urandom_range(300, 6000), $urandom_range(3, 10), 2);
        end
        run_segment(0, 9000, 6, 1);
        rdy_mode = 1;
        run_segment(0, 0, 2, 0);

        // Clear while an output is held
        set_write(SR_BASE + 1, 0);
        set_write(SR_BASE, 4096);
        pulse_clear();
        push_exp(iq(10, 0)); push_exp(iq(20, 0));
        send(10, 0, 0); send(20, 0, 0); send(30, 0, 0);
        wait_drain("pre_clr");
        rdy_mode = 0;
        repeat (2) tick();
        send(40, 0, 0);
        wait_valid("clr_held");
        tick();
        pulse_clear();
        @(negedge clk);
        check("clr_tvalid", 32'(o_tvalid), 0);
        check("clr_out_cnt", o_out_cnt, 0);
        check("clr_rdy", 32'(o_rdy), 1);
        tick();
        rdy_mode = 1;
        push_exp(iq(50, 0)); push_exp(iq(60, 0));
        send(50, 0, 0); send(60, 0, 0); send(70, 0, 0);
        wait_drain("post_clr");

        // Reset while waiting in LOAD
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_tvalid", 32'(o_tvalid), 0);
        check("rst2_out_cnt", o_out_cnt, 0);
        check("rst2_rdy", 32'(o_rdy), 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        cnt_model = 0;
        push_exp(iq(80, 0)); push_exp(iq(90, 0));
        send(80, 0, 0); send(90, 0, 0); send(100, 0, 0);
        wait_drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fract_resampler.md
FRACT_RESAMPLER -- requirements
Module: fract_resampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning signed bit width of each I and Q sample.
REQ-002 The block SHALL have parameter PHASE_W, default 12, meaning fractional phase accumulator width (mu in [0,1) with 2^PHASE_W steps).
REQ-003 The block SHALL have parameter SR_BASE, default 192, meaning settings-bus address of SR_STEP; SR_MODE is SR_BASE+1.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset, with ports as follows:
- i_clk, input, 1: sole clock; all logic rising-edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_clear, input, 1: synchronous clear.
- i_din_i, input, WIDTH: input sample I.
- i_din_q, input, WIDTH: input sample Q.
- i_din_vld, input, 1: input sample valid.
- o_rdy, output, 1: block accepts input; transfer = i_din_vld & o_rdy.
- o_tdata, output, 2*WIDTH: output sample {I,Q}, I in upper half.
- o_tvalid, output, 1: output valid.
- i_rdy, input, 1: downstream ready; transfer = o_tvalid & i_rdy.
- i_set_stb, input, 1: settings write strobe.
- i_set_addr, input, 8: settings address.
- i_set_data, input, 32: settings data.
- o_out_cnt, output, 32: count of output transfers, wraps.

Function
REQ-005 SR_STEP SHALL hold step[PHASE_W:0], unsigned, 2^PHASE_W = 1.0; output rate = fs_in*2^PHASE_W/step; writes of 0 SHALL load 1; writes above 2^PHASE_W SHALL clamp to 2^PHASE_W.
REQ-006 SR_MODE bit0 SHALL select bypass (1) or interpolate (0); writing bit1=1 SHALL issue a one-cycle clear equivalent to i_clear; bit1 SHALL not be stored.
REQ-007 The FSM SHALL have states FILL, CALC, OUT, LOAD, BYP.
REQ-008 In FILL, o_rdy=1; each input transfer SHALL shift x0<=x1, x1<=din; after the second transfer it SHALL enter CALC with mu=0.
REQ-009 In CALC (one cycle, o_rdy=0, o_tvalid=0), the block SHALL register prod=(x1-x0)*mu per channel, with the difference WIDTH+1 bits signed and the product WIDTH+PHASE_W+2 bits signed.
REQ-010 In OUT, o_tvalid=1 and o_tdata = x0 + ((prod + 2^(PHASE_W-1)) >>> PHASE_W), truncated to WIDTH (round half up); the result lies within [x0,x1], so no saturation is required.
REQ-011 In OUT, o_tdata SHALL be held stable until i_rdy; on transfer: {carry,mu} <= mu+step; carry=0 -> CALC, carry=1 -> LOAD.
REQ-012 In LOAD, o_rdy=1; on input transfer the block SHALL do x0<=x1, x1<=din and go to CALC; it SHALL wait indefinitely for i_din_vld.
REQ-013 Throughput in interpolate mode SHALL be at most one output per 2 cycles; latency from the second FILL input to the first o_tvalid SHALL be 2 cycles.
REQ-014 A step write SHALL take effect at the next mu update; a write concurrent with an OUT transfer SHALL use the old step for that update.
REQ-015 In BYP, the block SHALL act as a one-stage register slice: o_rdy = !o_tvalid | i_rdy; o_tdata = registered {din_i,din_q}; no samples SHALL be dropped or duplicated.
REQ-016 A mode change SHALL act as a clear: go to FILL (interpolate) or BYP (bypass), drop any held output, set mu=0 and x0=x1=0.
REQ-017 i_clear SHALL perform the same actions as a mode change into the current mode and SHALL zero o_out_cnt; clear takes priority over a simultaneous transfer.
REQ-018 o_out_cnt SHALL increment on every output transfer in either mode and SHALL wrap from 2^32-1 to 0.

Reset
REQ-019 On i_rst_n low, regardless of clock: state=FILL, step=2^PHASE_W, bypass=0, mu=0, x0=x1=0, o_tvalid=0, o_tdata=0, o_rdy=1, o_out_cnt=0.
REQ-020 Reset release SHALL be synchronised internally; the first transfer SHALL be accepted no earlier than the second clock edge after deassertion.
REQ-021 Reset mid-operation SHALL discard any held sample or output without emitting it.

Verification (WIDTH=16, PHASE_W=12)
REQ-022 Default step 4096, I inputs 100, 200, 300 with Q=0, i_rdy=1 -> outputs I=100 then 200; o_out_cnt=2.
REQ-023 Step 2048, I inputs 0, 1000, 2000 -> outputs 0, 500, 1000, 1500; with x0=0, x1=-3, mu=2048 -> output -1.
REQ-024 Step 1365, I inputs 0, 4096 -> outputs 0, 1365, 2730, 4095, then LOAD with mu=1364.
REQ-025 i_rdy held low 10 cycles during OUT -> o_tdata stable, o_rdy=0, mu unchanged, o_out_cnt unchanged.
REQ-026 SR_MODE=1 with inputs 7, 8, 9 back-to-back and i_rdy=1 -> outputs 7, 8, 9 on consecutive cycles with 1-cycle latency.
REQ-027 i_clear asserted in OUT (and separately i_rst_n low in LOAD) -> o_tvalid=0 next cycle, state FILL, o_out_cnt=0, and the next two inputs refill.
